// File: rtl/ccm_loader_if.sv
// Byte-stream, SRAM write and status bundle for the CCM loader.
// master: image source / SRAM side (testbench); slave: the loader itself.
interface ccm_loader_if #(
    parameter int unsigned AW = 11
) ();
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_last;
    logic          byte_ready;
    logic [AW-1:0] sram_addr;
    logic          eve_wen;
    logic          odd_wen;
    logic [63:0]   eve_data;
    logic [63:0]   odd_data;
    logic          core_rstn;
    logic          load_done;
    logic          load_err;

    modport master (
        output byte_valid, byte_data, byte_last,
        input  byte_ready, sram_addr, eve_wen, odd_wen, eve_data, odd_data,
        input  core_rstn, load_done, load_err
    );

    modport slave (
        input  byte_valid, byte_data, byte_last,
        output byte_ready, sram_addr, eve_wen, odd_wen, eve_data, odd_data,
        output core_rstn, load_done, load_err
    );
endinterface

// File: rtl/ccm_loader.sv
// CCM image loader: packs an incoming byte stream into 16-byte lines, writes
// each line to an even/odd SRAM bank pair, zero-fills the remaining lines and
// then releases the core reset. Overflowing 2**AW lines is a terminal error.
module ccm_loader #(
    parameter int unsigned AW = 11
) (
    input logic           CLK,
    input logic           RSTn,
    ccm_loader_if.slave   bus
);
    typedef enum logic [2:0] {
        StRecv,
        StWrite,
        StZfill,
        StDone,
        StErr
    } state_e;

    localparam logic [AW-1:0] LineMax = '1;

    state_e         r_state;
    logic [3:0]     r_byte_cnt;
    logic [AW-1:0]  r_line;
    logic [127:0]   r_buf;
    logic           r_last;

    state_e         w_state_d;
    logic [3:0]     w_byte_cnt_d;
    logic [AW-1:0]  w_line_d;
    logic [127:0]   w_buf_d;
    logic           w_last_d;

    logic           w_ready;
    logic           w_wen;
    logic [127:0]   w_wdata;
    logic           w_done;
    logic           w_err;

    // State register; async reset restarts the load from line 0.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= StRecv;
            r_byte_cnt <= '0;
            r_line     <= '0;
            r_buf      <= '0;
            r_last     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_byte_cnt <= w_byte_cnt_d;
            r_line     <= w_line_d;
            r_buf      <= w_buf_d;
            r_last     <= w_last_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_state_d    = r_state;
        w_byte_cnt_d = r_byte_cnt;
        w_line_d     = r_line;
        w_buf_d      = r_buf;
        w_last_d     = r_last;
        w_ready      = 1'b0;
        w_wen        = 1'b0;
        w_wdata      = '0;
        w_done       = 1'b0;
        w_err        = 1'b0;

        unique case (r_state)
            StRecv: begin
                w_ready = 1'b1;
                if (bus.byte_valid) begin
                    w_buf_d[{r_byte_cnt, 3'b000} +: 8] = bus.byte_data;
                    w_byte_cnt_d = r_byte_cnt + 4'd1;
                    w_last_d     = bus.byte_last;
                    if (bus.byte_last || (r_byte_cnt == 4'd15)) begin
                        w_state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                w_wen        = 1'b1;
                w_wdata      = r_buf;
                w_byte_cnt_d = '0;
                if (r_last) begin
                    if (r_line == LineMax) begin
                        w_state_d = StDone;
                    end else begin
                        w_state_d = StZfill;
                        w_line_d  = r_line + 1'b1;
                    end
                end else if (r_line == LineMax) begin
                    // A full last line without byte_last: the image does not fit.
                    w_state_d = StErr;
                end else begin
                    w_state_d = StRecv;
                    w_line_d  = r_line + 1'b1;
                    w_buf_d   = '0;
                end
            end
            StZfill: begin
                w_wen = 1'b1;
                if (r_line == LineMax) begin
                    w_state_d = StDone;
                end else begin
                    w_line_d = r_line + 1'b1;
                end
            end
            StDone: begin
                w_done = 1'b1;
            end
            StErr: begin
                w_err = 1'b1;
            end
            default: begin
                w_state_d = StErr;
            end
        endcase
    end

    assign bus.byte_ready = w_ready;
    assign bus.sram_addr  = r_line;
    assign bus.eve_wen    = w_wen;
    assign bus.odd_wen    = w_wen;
    assign bus.eve_data   = w_wdata[63:0];
    assign bus.odd_data   = w_wdata[127:64];
    assign bus.core_rstn  = w_done;
    assign bus.load_done  = w_done;
    assign bus.load_err   = w_err;
endmodule

// File: tb/tb_ccm_loader.sv
// Self-checking bench for ccm_loader: a byte-log model predicts every SRAM write,
// the handshake and the status outputs each cycle; directed tests pin literals.
module tb_ccm_loader;
    localparam int unsigned AW    = 11;
    localparam int          Lines = 2048;

    logic CLK;
    logic RSTn;

    ccm_loader_if #(.AW(AW)) bus ();

    ccm_loader #(.AW(AW)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Model: log of accepted bytes; line L holds bytes 16L..16L+15, zero past the end.
    logic [7:0]  m_mem [0:32799];
    int          m_acc;
    bit          m_close;
    bit          m_last;
    bit          m_zfill;
    int          m_written;

    // Observations for the directed literal checks.
    logic [AW-1:0] cap_addr [0:3];
    logic [63:0]   cap_eve  [0:3];
    logic [63:0]   cap_odd  [0:3];
    int            wen_n;
    int            hs_n;

    logic        e_ready;
    logic        e_wen;
    logic        e_done;
    logic        e_err;
    logic [63:0] e_eve;
    logic [63:0] e_odd;
    bit          ok_cyc;

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge CLK) begin
        if (!RSTn) begin
            m_acc = 0; m_close = 0; m_last = 0; m_zfill = 0; m_written = 0;
            wen_n = 0; hs_n = 0;
        end else begin
            e_ready = !m_close && !m_zfill && (m_written < Lines);
            e_wen   = m_close || m_zfill;
            e_done  = (m_written == Lines) && m_last;
            e_err   = (m_written == Lines) && !m_last;
            for (int k = 0; k < 8; k++) begin
                e_eve[8*k +: 8] = (16*m_written + k < m_acc) ? m_mem[16*m_written + k] : 8'h00;
                e_odd[8*k +: 8] = (16*m_written + 8 + k < m_acc) ?
                                  m_mem[16*m_written + 8 + k] : 8'h00;
            end
            ok_cyc = (bus.byte_ready === e_ready) && (bus.eve_wen === e_wen) &&
                     (bus.odd_wen === e_wen) && (bus.load_done === e_done) &&
                     (bus.load_err === e_err) && (bus.core_rstn === e_done);
            if (e_wen) begin
                ok_cyc = ok_cyc && (bus.sram_addr === AW'(m_written)) &&
                         (bus.eve_data === e_eve) && (bus.odd_data === e_odd);
            end
            n_checks++;
            if (!ok_cyc) begin
                n_errors++;
                $display("FAIL cycle t=%0t (got/exp): rdy=%b/%b wen=%b%b/%b addr=%0d/%0d eve=%h/%h odd=%h/%h done=%b/%b err=%b/%b crst=%b/%b",
                         $time, bus.byte_ready, e_ready, bus.eve_wen, bus.odd_wen, e_wen,
                         bus.sram_addr, m_written, bus.eve_data, e_eve, bus.odd_data, e_odd,
                         bus.load_done, e_done, bus.load_err, e_err, bus.core_rstn, e_done);
            end
            if (bus.eve_wen) begin
                if (wen_n < 4) begin
                    cap_addr[wen_n] = bus.sram_addr;
                    cap_eve[wen_n]  = bus.eve_data;
                    cap_odd[wen_n]  = bus.odd_data;
                end
                wen_n++;
            end
            if (bus.byte_valid && bus.byte_ready) hs_n++;
            // Advance the model.
            if (e_wen) begin
                m_written++;
                if (m_close) begin
                    m_close = 0;
                    if (m_last && m_written < Lines) m_zfill = 1;
                end else if (m_written == Lines) begin
                    m_zfill = 0;
                end
            end
            if (bus.byte_valid && e_ready) begin
                m_mem[m_acc] = bus.byte_data;
                m_acc++;
                if (bus.byte_last || (m_acc % 16 == 0)) begin
                    m_close = 1;
                    m_last  = bus.byte_last;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_wen"},    64'({bus.eve_wen, bus.odd_wen}), 64'd0);
        chk({name, "_addr"},   64'(bus.sram_addr), 64'd0);
        chk({name, "_data"},   bus.eve_data | bus.odd_data, 64'd0);
        chk({name, "_status"}, 64'({bus.core_rstn, bus.load_done, bus.load_err}), 64'd0);
    endtask

    task automatic do_reset(input string name);
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        @(negedge CLK);
        #2;
        RSTn = 1'b0;
        #1;
        check_reset_outputs(name);
        @(negedge CLK);
        #2;
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [7:0] byte_val(input int kind, input int i);
        logic [7:0] v;
        case (kind)
            0:       v = 8'(i);
            1:       v = 8'(i + 1);
            2:       v = 8'(i ^ (i >> 8));
            3:       v = 8'(8'hA0 + i);
            default: v = 8'(8'h30 + i);
        endcase
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic l, input int max_wait,
                             output bit ok);
        logic rdy;
        int   w;
        ok = 0;
        w  = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = d;
        bus.byte_last  = l;
        while (!ok && w < max_wait) begin
            @(negedge CLK);
            rdy = bus.byte_ready;
            @(posedge CLK);
            #1;
            if (rdy) ok = 1;
            w++;
        end
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
    endtask

    task automatic send_seq(input int n, input int kind, input bit mark_last, input int max_gap);
        bit ok;
        for (int i = 0; i < n; i++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    @(posedge CLK);
                    #1;
                end
            end
            send_byte(byte_val(kind, i), mark_last && (i == n - 1), 100, ok);
            if (!ok) begin
                n_checks++;
                n_errors++;
                $display("FAIL byte_accept_timeout: byte %0d got not-accepted, expected accepted", i);
            end
        end
    endtask

    task automatic wait_wen(input int n, input int budget, input string name);
        int w = 0;
        while (wen_n < n && w < budget) begin
            @(posedge CLK);
            #1;
            w++;
        end
        if (wen_n < n) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got %0d writes, expected %0d", name, wen_n, n);
        end
    endtask

    task automatic wait_term(input int budget, input string name);
        int w = 0;
        while (!(bus.load_done || bus.load_err) && w < budget) begin
            @(posedge CLK);
            #1;
            w++;
        end
        if (!(bus.load_done || bus.load_err)) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got no terminal state, expected done or err", name);
        end
    endtask

    bit ok_b;

    initial begin
        RSTn           = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.byte_last  = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        check_reset_outputs("por");
        #1;
        RSTn = 1'b1;
        @(posedge CLK);
        #1;

        // 16 bytes, last on lane 15: one data line then 2047 zero lines.
        send_seq(16, 0, 1'b1, 0);
        wait_term(3000, "t1");
        @(negedge CLK);
        chk("t1_addr0", 64'(cap_addr[0]), 64'd0);
        chk("t1_eve0", cap_eve[0], 64'h0706050403020100);
        chk("t1_odd0", cap_odd[0], 64'h0F0E0D0C0B0A0908);
        chk("t1_zfill1", 64'(cap_addr[1]) | (cap_eve[1] | cap_odd[1]) << 16, 64'd1);
        chk("t1_writes", 64'(wen_n), 64'd2048);
        chk("t1_done", 64'({bus.load_done, bus.core_rstn, bus.load_err}), 64'b110);
        @(posedge CLK);
        #1;
        send_byte(8'h55, 1'b0, 10, ok_b);
        chk("t1_no_accept_done", 64'(ok_b), 64'd0);
        chk("t1_handshakes", 64'(hs_n), 64'd16);

        // 20 bytes: full line 0, partial line 1, zero fill from line 2; reset mid-fill.
        do_reset("rst_t2");
        send_seq(20, 1, 1'b1, 0);
        wait_wen(4, 100, "t2");
        chk("t2_eve0", cap_eve[0], 64'h0807060504030201);
        chk("t2_odd0", cap_odd[0], 64'h100F0E0D0C0B0A09);
        chk("t2_addr1", 64'(cap_addr[1]), 64'd1);
        chk("t2_eve1", cap_eve[1], 64'h0000000014131211);
        chk("t2_odd1", cap_odd[1], 64'd0);
        chk("t2_addr2", 64'(cap_addr[2]), 64'd2);
        chk("t2_zero2", cap_eve[2] | cap_odd[2], 64'd0);
        do_reset("rst_mid_zfill");

        // Exactly 32768 bytes with last on the final byte: no zero fill.
        send_seq(32768, 2, 1'b1, 0);
        wait_term(100, "t3");
        chk("t3_writes", 64'(wen_n), 64'd2048);
        chk("t3_status", 64'({bus.load_done, bus.load_err, bus.core_rstn}), 64'b101);

        // 32769 bytes without last: overflow error, extra byte refused.
        do_reset("rst_t4");
        send_seq(32768, 2, 1'b0, 0);
        send_byte(8'hEE, 1'b0, 30, ok_b);
        chk("t4_byte32769_refused", 64'(ok_b), 64'd0);
        chk("t4_status", 64'({bus.load_err, bus.load_done, bus.core_rstn}), 64'b100);
        chk("t4_handshakes", 64'(hs_n), 64'd32768);
        chk("t4_writes", 64'(wen_n), 64'd2048);

        // Same 20-byte image with random valid gaps.
        do_reset("rst_t5");
        send_seq(20, 1, 1'b1, 3);
        wait_wen(3, 100, "t5");
        chk("t5_eve0", cap_eve[0], 64'h0807060504030201);
        chk("t5_odd0", cap_odd[0], 64'h100F0E0D0C0B0A09);
        chk("t5_eve1", cap_eve[1], 64'h0000000014131211);
        chk("t5_odd1", cap_odd[1], 64'd0);

        // Reset after 9 bytes, then a fresh 16-byte image.
        do_reset("rst_t6a");
        send_seq(9, 3, 1'b0, 0);
        do_reset("rst_mid_line");
        send_seq(16, 4, 1'b1, 0);
        wait_wen(2, 100, "t6");
        chk("t6_addr0", 64'(cap_addr[0]), 64'd0);
        chk("t6_eve0", cap_eve[0], 64'h3736353433323130);
        chk("t6_odd0", cap_odd[0], 64'h3F3E3D3C3B3A3938);
        chk("t6_handshakes", 64'(hs_n), 64'd16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
